// File: rtl/risc_boot_sequencer.sv
// Boot/program-load controller for one Risc core: streams a program into code memory,
// pulses boot, then runs the core under a cycle watchdog and latches its result.
module risc_boot_sequencer #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int MAX_CYCLES = 1000,
   parameter int CNT_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_start,
   input  logic              io_abort,
   input  logic [ADDR_W:0]   io_progLen,
   input  logic              io_srcValid,
   output logic              io_srcReady,
   input  logic [DATA_W-1:0] io_srcData,
   output logic              io_riscBoot,
   output logic              io_riscIsWr,
   output logic [ADDR_W-1:0] io_riscWrAddr,
   output logic [DATA_W-1:0] io_riscWrData,
   input  logic [DATA_W-1:0] io_riscOut,
   input  logic              io_riscValid,
   output logic              io_busy,
   output logic              io_done,
   output logic              io_timeout,
   output logic [DATA_W-1:0] io_result,
   output logic [CNT_W-1:0]  io_cycles
);

   // state   | meaning
   // IDLE    | waiting for start, Risc held in boot
   // LOAD    | accepting program words, one write per handshake
   // BOOT    | single cycle with boot high to reset the Risc PC
   // RUN     | Risc executing, watchdog counting
   // DONE    | result captured, held until next start/abort
   // TIMEOUT | watchdog expired, held until next start/abort
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_BOOT, S_RUN, S_DONE, S_TIMEOUT
   } state_t;

   localparam int LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(2 ** ADDR_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [CNT_W-1:0]    cycles_q, cycles_d;
   logic                done_q, done_d;
   logic                timeout_q, timeout_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      cycles_d  = cycles_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      if (io_abort) begin
         state_d   = S_IDLE;
         addr_d    = '0;
         cnt_d     = '0;
         done_d    = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
               if (io_start) begin
                  len_d     = (io_progLen > LEN_MAX) ? LEN_MAX : io_progLen;
                  addr_d    = '0;
                  cnt_d     = '0;
                  done_d    = 1'b0;
                  timeout_d = 1'b0;
                  state_d   = (io_progLen == '0) ? S_BOOT : S_LOAD;
               end
            end
            S_LOAD: begin
               if (io_srcValid) begin
                  addr_d = addr_q + ADDR_W'(1);
                  if ({1'b0, addr_q} == len_q - LEN_W'(1)) state_d = S_BOOT;
               end
            end
            S_BOOT: begin
               cnt_d   = '0;
               state_d = S_RUN;
            end
            S_RUN: begin
               // a valid in the expiry cycle still counts as a completed run
               if (io_riscValid) begin
                  result_d = io_riscOut;
                  cycles_d = cnt_q + CNT_W'(1);
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     cycles_d  = CNT_MAX;
                     timeout_d = 1'b1;
                     state_d   = S_TIMEOUT;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         cycles_q  <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         cycles_q  <= cycles_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   assign io_srcReady   = (state_q == S_LOAD);
   assign io_riscIsWr   = (state_q == S_LOAD) && io_srcValid;
   assign io_riscWrAddr = addr_q;
   assign io_riscWrData = io_srcData;
   assign io_riscBoot   = (state_q != S_RUN);
   assign io_busy       = (state_q == S_LOAD) || (state_q == S_BOOT) || (state_q == S_RUN);
   assign io_done       = done_q;
   assign io_timeout    = timeout_q;
   assign io_result     = result_q;
   assign io_cycles     = cycles_q;

endmodule

// File: tb/tb_risc_boot_sequencer.sv
// Scoreboard bench for risc_boot_sequencer: expected code-memory writes and run results
// are queued as stimulus is driven and checked when the DUT produces them.
module tb_risc_boot_sequencer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int MAXC   = 8;
   localparam int CNT_W  = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              io_start, io_abort, io_srcValid, io_riscValid;
   logic [ADDR_W:0]   io_progLen;
   logic [DATA_W-1:0] io_srcData, io_riscOut;
   logic              io_srcReady, io_riscBoot, io_riscIsWr, io_busy, io_done, io_timeout;
   logic [ADDR_W-1:0] io_riscWrAddr;
   logic [DATA_W-1:0] io_riscWrData, io_result;
   logic [CNT_W-1:0]  io_cycles;

   risc_boot_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .io_start(io_start), .io_abort(io_abort),
      .io_progLen(io_progLen), .io_srcValid(io_srcValid), .io_srcReady(io_srcReady),
      .io_srcData(io_srcData), .io_riscBoot(io_riscBoot), .io_riscIsWr(io_riscIsWr),
      .io_riscWrAddr(io_riscWrAddr), .io_riscWrData(io_riscWrData), .io_riscOut(io_riscOut),
      .io_riscValid(io_riscValid), .io_busy(io_busy), .io_done(io_done),
      .io_timeout(io_timeout), .io_result(io_result), .io_cycles(io_cycles)
   );

   always #5 clock = ~clock;

   typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
   typedef struct packed { logic to; logic [DATA_W-1:0] r; logic [CNT_W-1:0] c; } res_t;
   wr_t  wr_q[$];
   res_t res_q[$];

   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W-1:0] last_res = '0;
   logic prev_done = 1'b0, prev_to = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (io_riscIsWr) begin
            if (wr_q.size() == 0) chk("wr_unexp", 64'(io_riscIsWr), 64'd0);
            else begin
               wr_t e;
               e = wr_q.pop_front();
               chk("wr_addr", 64'(io_riscWrAddr), 64'(e.a));
               chk("wr_data", 64'(io_riscWrData), 64'(e.d));
            end
         end
         if ((io_done && !prev_done) || (io_timeout && !prev_to)) begin
            if (res_q.size() == 0) chk("res_unexp", 64'(io_done | io_timeout), 64'd0);
            else begin
               res_t r;
               r = res_q.pop_front();
               chk("res_to",  64'(io_timeout), 64'(r.to));
               chk("res_val", 64'(io_result),  64'(r.r));
               chk("res_cyc", 64'(io_cycles),  64'(r.c));
            end
         end
      end
      prev_done <= io_done;
      prev_to   <= io_timeout;
   end

   task automatic do_start(input int len);
      io_start   = 1'b1;
      io_progLen = (ADDR_W+1)'(len);
      @(posedge clock); #1;
      io_start   = 1'b0;
      chk("st_done",  64'(io_done), 64'd0);
      chk("st_to",    64'(io_timeout), 64'd0);
      chk("st_busy",  64'(io_busy), 64'd1);
      chk("st_rdy",   64'(io_srcReady), 64'(len != 0));
      chk("st_boot",  64'(io_riscBoot), 64'd1);
   endtask

   // BOOT cycle: srcValid held high to show no write leaks out
   task automatic boot_step();
      io_srcValid = 1'b1;
      io_srcData  = 32'hFFFF_FFFF;
      @(negedge clock);
      chk("bt_boot", 64'(io_riscBoot), 64'd1);
      chk("bt_busy", 64'(io_busy), 64'd1);
      chk("bt_rdy",  64'(io_srcReady), 64'd0);
      chk("bt_wr",   64'(io_riscIsWr), 64'd0);
      @(posedge clock); #1;
      io_srcValid = 1'b0;
   endtask

   // pat gives srcValid per cycle, LSB first; all ones after 16 cycles
   task automatic load_prog(input int n, input logic [DATA_W-1:0] base,
                            input logic [15:0] pat, input bit full);
      int i = 0;
      int c = 0;
      while (i < n && c < 64) begin
         logic v;
         v = (c < 16) ? pat[c] : 1'b1;
         io_srcValid = v;
         io_srcData  = v ? base + DATA_W'(i) : 32'h0000_0BAD;
         if (v) wr_q.push_back('{a: ADDR_W'(i), d: base + DATA_W'(i)});
         @(negedge clock);
         chk("ld_rdy", 64'(io_srcReady), 64'd1);
         chk("ld_boot", 64'(io_riscBoot), 64'd1);
         @(posedge clock); #1;
         if (v) i++;
         c++;
      end
      io_srcValid = 1'b0;
      if (full) boot_step();
   endtask

   // vcyc = RUN cycle on which valid is raised, 0 = never; start_at = RUN cycle to pulse start
   task automatic run_phase(input int vcyc, input logic [DATA_W-1:0] out, input int start_at);
      int ncyc;
      if (vcyc > 0) begin
         res_q.push_back('{to: 1'b0, r: out, c: CNT_W'(vcyc)});
         last_res = out;
         ncyc = vcyc;
      end else begin
         res_q.push_back('{to: 1'b1, r: last_res, c: CNT_W'(MAXC)});
         ncyc = MAXC;
      end
      for (int k = 1; k <= ncyc; k++) begin
         io_riscValid = (k == vcyc);
         io_riscOut   = (k == vcyc) ? out : 32'hDEAD_0000 + DATA_W'(k);
         io_start     = (k == start_at);
         io_progLen   = 9'd5;
         @(negedge clock);
         chk("rn_boot", 64'(io_riscBoot), 64'd0);
         chk("rn_busy", 64'(io_busy), 64'd1);
         @(posedge clock); #1;
      end
      io_riscValid = 1'b0;
      io_start     = 1'b0;
      @(negedge clock);
      chk("end_done", 64'(io_done), 64'(vcyc > 0));
      chk("end_to",   64'(io_timeout), 64'(vcyc == 0));
      chk("end_boot", 64'(io_riscBoot), 64'd1);
      chk("end_busy", 64'(io_busy), 64'd0);
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; io_start = 0; io_abort = 0; io_progLen = '0; io_srcValid = 0;
      io_srcData = '0; io_riscOut = '0; io_riscValid = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_busy",   64'(io_busy), 64'd0);
      chk("rst_done",   64'(io_done), 64'd0);
      chk("rst_to",     64'(io_timeout), 64'd0);
      chk("rst_rdy",    64'(io_srcReady), 64'd0);
      chk("rst_wr",     64'(io_riscIsWr), 64'd0);
      chk("rst_boot",   64'(io_riscBoot), 64'd1);
      chk("rst_result", 64'(io_result), 64'd0);
      chk("rst_cycles", 64'(io_cycles), 64'd0);
      @(posedge clock); #1;

      // back-to-back load, valid on 5th run cycle
      do_start(3);
      load_prog(3, 32'hA, 16'hFFFF, 1'b1);
      run_phase(5, 32'h2A, 0);

      // restart from DONE, stalled source, start pulse during RUN ignored
      do_start(3);
      load_prog(3, 32'hA, 16'b0000_0000_0010_1001, 1'b1);
      run_phase(3, 32'h77, 2);

      // resident program
      do_start(0);
      boot_step();
      run_phase(2, 32'h55, 0);

      // watchdog expiry, then valid exactly on the last allowed cycle
      do_start(1);
      load_prog(1, 32'h100, 16'hFFFF, 1'b1);
      run_phase(0, '0, 0);
      do_start(2);
      load_prog(2, 32'h200, 16'hFFFF, 1'b1);
      run_phase(MAXC, 32'h88, 0);

      // abort mid-load, then full reload from address 0
      do_start(4);
      load_prog(2, 32'h300, 16'hFFFF, 1'b0);
      io_abort = 1'b1;
      @(posedge clock); #1;
      io_abort = 1'b0;
      chk("ab_busy",   64'(io_busy), 64'd0);
      chk("ab_boot",   64'(io_riscBoot), 64'd1);
      chk("ab_rdy",    64'(io_srcReady), 64'd0);
      chk("ab_done",   64'(io_done), 64'd0);
      chk("ab_result", 64'(io_result), 64'(last_res));
      do_start(4);
      load_prog(4, 32'h40, 16'hFFFF, 1'b1);
      run_phase(1, 32'hC0FFEE, 0);

      chk("wr_left",  64'(wr_q.size()), 64'd0);
      chk("res_left", 64'(res_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
